// File: rtl/fetch_queue_n.sv
// Instruction-fetch front end: issues aligned fetch-block requests to the I-cache and
// buffers returned words in a circular queue that decode drains up to ISSUE_W per cycle.
module fetch_queue_n #(
  parameter int          ISSUE_W    = 2,
  parameter int          DEPTH      = 8,
  parameter logic [31:0] RESET_PC   = 32'hbfc0_0000,
  parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic                           req_valid,
  output logic [31:0]                    req_pc,
  input  logic                           req_ready,
  input  logic                           rsp_valid,
  input  logic [32*ISSUE_W-1:0]          rsp_inst,
  input  logic                           redirect_valid,
  input  logic [31:0]                    redirect_pc,
  input  logic                           exc_req,
  input  logic [$clog2(ISSUE_W+1)-1:0]   id_take,
  output logic [ISSUE_W-1:0]             id_valid,
  output logic [32*ISSUE_W-1:0]          id_inst,
  output logic [32*ISSUE_W-1:0]          id_pc,
  output logic [ISSUE_W-1:0]             id_adel
);

  localparam int          PTR_W     = $clog2(DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam int          OFF_BITS  = $clog2(4 * ISSUE_W);
  localparam logic [31:0] BLK_BYTES = 32'(4 * ISSUE_W);
  localparam logic [31:0] BLK_MASK  = ~(BLK_BYTES - 32'd1);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALT} state_t;

  state_t              state_q, state_d;
  logic [31:0]         fetch_pc_q, fetch_pc_d;
  logic                drop_q, drop_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [31:0]         mem_inst_q [DEPTH];
  logic [31:0]         mem_inst_d [DEPTH];
  logic [31:0]         mem_pc_q   [DEPTH];
  logic [31:0]         mem_pc_d   [DEPTH];
  logic                mem_adel_q [DEPTH];
  logic                mem_adel_d [DEPTH];

  logic [CNT_W-1:0]    take;
  logic [CNT_W-1:0]    free_after;
  logic [CNT_W-1:0]    off;
  logic [CNT_W-1:0]    push;
  logic                misaligned;
  logic                handshake;

  // Request side: credit counts entries freed by this cycle's decode take.
  always_comb begin
    take       = (CNT_W'(id_take) > count_q) ? count_q : CNT_W'(id_take);
    free_after = CNT_W'(DEPTH) - count_q + take;
    misaligned = (fetch_pc_q[1:0] != 2'b00);
    req_pc     = fetch_pc_q & BLK_MASK;
    off        = CNT_W'(fetch_pc_q[OFF_BITS-1:0] >> 2);
    req_valid  = reset && (state_q == S_REQ) && !misaligned &&
                 (free_after >= CNT_W'(ISSUE_W));
    handshake  = req_valid && req_ready;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    mem_inst_d = mem_inst_q;
    mem_pc_d   = mem_pc_q;
    mem_adel_d = mem_adel_q;
    push       = '0;

    if (exc_req || redirect_valid) begin
      fetch_pc_d = exc_req ? EXC_VECTOR : redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      // A request the cache already owns must have its response swallowed.
      if (((state_q == S_WAIT) && !rsp_valid) || handshake) begin
        state_d = S_WAIT;
        drop_d  = 1'b1;
      end else begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    end else begin
      case (state_q)
        S_REQ: begin
          if (misaligned) begin
            if (free_after >= CNT_W'(1)) begin
              mem_inst_d[tail_q] = '0;
              mem_pc_d[tail_q]   = fetch_pc_q;
              mem_adel_d[tail_q] = 1'b1;
              push               = CNT_W'(1);
              state_d            = S_HALT;
            end
          end else if (handshake) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (rsp_valid) begin
            state_d = S_REQ;
            if (drop_q) begin
              drop_d = 1'b0;
            end else begin
              // Words below the entry offset precede the fetch PC and are skipped.
              for (int i = 0; i < ISSUE_W; i++) begin
                if (CNT_W'(i) >= off) begin
                  mem_inst_d[tail_q + PTR_W'(CNT_W'(i) - off)] = rsp_inst[32*i +: 32];
                  mem_pc_d[tail_q + PTR_W'(CNT_W'(i) - off)]   = req_pc + 32'(4 * i);
                  mem_adel_d[tail_q + PTR_W'(CNT_W'(i) - off)] = 1'b0;
                end
              end
              push       = CNT_W'(ISSUE_W) - off;
              fetch_pc_d = req_pc + BLK_BYTES;
            end
          end
        end
        default: ;
      endcase
      head_d  = head_q + PTR_W'(take);
      tail_d  = tail_q + PTR_W'(push);
      count_d = count_q + push - take;
    end
  end

  // Decode view: slot i is queue entry head+i; empty slots read as zero.
  always_comb begin
    id_valid = '0;
    id_inst  = '0;
    id_pc    = '0;
    id_adel  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (CNT_W'(i) < count_q) begin
        id_valid[i]        = 1'b1;
        id_inst[32*i +: 32] = mem_inst_q[head_q + PTR_W'(i)];
        id_pc[32*i +: 32]   = mem_pc_q[head_q + PTR_W'(i)];
        id_adel[i]         = mem_adel_q[head_q + PTR_W'(i)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Queue storage holds data only; validity comes from count_q.
  always_ff @(posedge clk) begin
    mem_inst_q <= mem_inst_d;
    mem_pc_q   <= mem_pc_d;
    mem_adel_q <= mem_adel_d;
  end

endmodule

// File: tb/tb_fetch_queue_n.sv
// Bench for fetch_queue_n (ISSUE_W=2, DEPTH=8): directed scenarios plus randomized
// traffic compared against a queue-based reference model of the fetch front end.
module tb_fetch_queue_n;
  localparam int          IW    = 2;
  localparam int          DEPTH = 8;
  localparam logic [31:0] RPC   = 32'hbfc0_0000;
  localparam logic [31:0] EXC   = 32'hbfc0_0380;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        rsp_valid;
  logic [63:0] rsp_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        exc_req;
  logic [1:0]  id_take;
  logic [1:0]  id_valid;
  logic [63:0] id_inst;
  logic [63:0] id_pc;
  logic [1:0]  id_adel;

  fetch_queue_n #(.ISSUE_W(IW), .DEPTH(DEPTH), .RESET_PC(RPC), .EXC_VECTOR(EXC)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_inst(rsp_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .exc_req(exc_req),
    .id_take(id_take), .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_adel(id_adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_fpc;
  bit          m_wait, m_halt, m_drop;
  int          checks = 0;
  int          errors = 0;

  function automatic int m_pop_n();
    int t;
    t = int'(id_take);
    return (t > mq.size()) ? mq.size() : t;
  endfunction

  function automatic bit m_req_valid();
    return reset && !m_wait && !m_halt && (m_fpc[1:0] == 2'b00) &&
           ((DEPTH - mq.size() + m_pop_n()) >= IW);
  endfunction

  // Advance one clock and apply the reference rules to the inputs held this cycle.
  task automatic cycle();
    bit          hs, rv, ex, rd, rn, pend;
    int          np, off;
    logic [31:0] rpc, rdpc;
    logic [63:0] ri;
    hs   = m_req_valid() && req_ready;
    np   = m_pop_n();
    rpc  = {m_fpc[31:3], 3'b000};
    off  = int'(m_fpc[2]);
    rv   = rsp_valid; ex = exc_req; rd = redirect_valid; rn = reset;
    rdpc = redirect_pc; ri = rsp_inst;
    @(posedge clk);
    if (!rn) begin
      mq.delete(); m_fpc = RPC; m_wait = 0; m_halt = 0; m_drop = 0;
    end else if (ex || rd) begin
      pend = (m_wait && !rv) || hs;
      mq.delete();
      m_fpc  = ex ? EXC : rdpc;
      m_wait = pend; m_drop = pend; m_halt = 0;
    end else begin
      repeat (np) void'(mq.pop_front());
      if (m_wait) begin
        if (rv) begin
          m_wait = 0;
          if (m_drop) m_drop = 0;
          else begin
            for (int i = off; i < IW; i++) mq.push_back('{ri[32*i +: 32], rpc + 32'(4*i), 1'b0});
            m_fpc = rpc + 32'd8;
          end
        end
      end else if (!m_halt) begin
        if (m_fpc[1:0] != 2'b00) begin
          if (DEPTH - mq.size() >= 1) begin
            mq.push_back('{32'd0, m_fpc, 1'b1});
            m_halt = 1;
          end
        end else if (hs) m_wait = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cycle(); cycle();
    #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    checks++; if (req_pc !== RPC) begin errors++; $display("FAIL reset_req_pc: got %h want %h", req_pc, RPC); end
    checks++; if (id_valid !== 2'b00 || id_adel !== 2'b00) begin errors++; $display("FAIL reset_id_valid: got %b/%b want 00/00", id_valid, id_adel); end
    checks++; if (id_inst !== 64'd0 || id_pc !== 64'd0) begin errors++; $display("FAIL reset_id_data: got %h/%h want 0", id_inst, id_pc); end
    reset = 1'b1;
    #1;
    checks++; if (req_valid !== 1'b1 || req_pc !== RPC) begin errors++; $display("FAIL first_req: got %b %h want 1 %h", req_valid, req_pc, RPC); end
  endtask

  task automatic test_first_fetch();
    req_ready = 1'b1;
    cycle();
    req_ready = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL wait_req_valid: got %b want 0", req_valid); end
    rsp_valid = 1'b1; rsp_inst = {32'hbbbb_0001, 32'haaaa_0000};
    cycle();
    rsp_valid = 1'b0;
    #1;
    checks++; if (id_valid !== 2'b11) begin errors++; $display("FAIL fetch_id_valid: got %b want 11", id_valid); end
    checks++; if (id_pc !== {32'hbfc0_0004, 32'hbfc0_0000}) begin errors++; $display("FAIL fetch_id_pc: got %h want bfc00004bfc00000", id_pc); end
    checks++; if (id_inst !== {32'hbbbb_0001, 32'haaaa_0000}) begin errors++; $display("FAIL fetch_id_inst: got %h", id_inst); end
    checks++; if (req_pc !== 32'hbfc0_0008 || req_valid !== 1'b1) begin errors++; $display("FAIL fetch_next_pc: got %b %h want 1 bfc00008", req_valid, req_pc); end
    id_take = 2'd2;
    cycle();
    id_take = 2'd0;
  endtask

  task automatic test_redirect_wait();
    req_ready = 1'b1;
    cycle();
    req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0004;
    cycle();
    redirect_valid = 1'b0;
    #1;
    checks++; if (id_valid !== 2'b00 || req_valid !== 1'b0) begin errors++; $display("FAIL redir_drain: got valid %b req %b want 00 0", id_valid, req_valid); end
    rsp_valid = 1'b1; rsp_inst = {32'hdead_0001, 32'hdead_0000};
    cycle();
    rsp_valid = 1'b0;
    #1;
    checks++; if (id_valid !== 2'b00) begin errors++; $display("FAIL redir_dropped: got %b want 00", id_valid); end
    checks++; if (req_valid !== 1'b1 || req_pc !== 32'h8000_0000) begin errors++; $display("FAIL redir_req: got %b %h want 1 80000000", req_valid, req_pc); end
    req_ready = 1'b1;
    cycle();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_inst = {32'h1111_2222, 32'h3333_4444};
    cycle();
    rsp_valid = 1'b0;
    #1;
    checks++; if (id_valid !== 2'b01 || id_pc[31:0] !== 32'h8000_0004) begin errors++; $display("FAIL redir_slot1: got %b %h want 01 80000004", id_valid, id_pc[31:0]); end
    checks++; if (id_inst[31:0] !== 32'h1111_2222 || req_pc !== 32'h8000_0008) begin errors++; $display("FAIL redir_inst: got %h %h want 11112222 80000008", id_inst[31:0], req_pc); end
    id_take = 2'd1;
    cycle();
    id_take = 2'd0;
  endtask

  task automatic test_credit();
    int blocks = 0;
    id_take = 2'd0; req_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      rsp_valid = m_wait; rsp_inst = {$urandom, $urandom};
      #1;
      if (req_valid && req_ready) blocks++;
      cycle();
    end
    rsp_valid = 1'b0;
    #1;
    checks++; if (blocks !== 4) begin errors++; $display("FAIL credit_blocks: got %0d want 4", blocks); end
    checks++; if (req_valid !== 1'b0 || id_valid !== 2'b11) begin errors++; $display("FAIL credit_full: got req %b valid %b want 0 11", req_valid, id_valid); end
    checks++; if (id_pc[31:0] !== 32'h8000_0008 || id_inst[31:0] !== mq[0].inst) begin errors++; $display("FAIL credit_head: got %h %h want 80000008 %h", id_pc[31:0], id_inst[31:0], mq[0].inst); end
    id_take = 2'd2;
    #1;
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL credit_reassert: got %b want 1", req_valid); end
    cycle();
    id_take = 2'd0; req_ready = 1'b0;
  endtask

  task automatic test_exc_redirect();
    exc_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0040;
    cycle();
    exc_req = 1'b0; redirect_valid = 1'b0;
    #1;
    checks++; if (req_pc !== EXC || id_valid !== 2'b00) begin errors++; $display("FAIL exc_target: got %h %b want %h 00", req_pc, id_valid, EXC); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL exc_drain: got %b want 0", req_valid); end
    rsp_valid = 1'b1; rsp_inst = {$urandom, $urandom};
    cycle();
    rsp_valid = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b1 || req_pc !== EXC || id_valid !== 2'b00) begin errors++; $display("FAIL exc_req: got %b %h %b want 1 %h 00", req_valid, req_pc, id_valid, EXC); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
    cycle();
    redirect_valid = 1'b0; req_ready = 1'b1;
    #1;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL adel_noreq: got %b want 0", req_valid); end
    repeat (4) cycle();
    #1;
    checks++; if (id_valid !== 2'b01 || id_adel !== 2'b01) begin errors++; $display("FAIL adel_entry: got %b %b want 01 01", id_valid, id_adel); end
    checks++; if (id_inst[31:0] !== 32'd0 || id_pc[31:0] !== 32'h8000_0002) begin errors++; $display("FAIL adel_data: got %h %h want 0 80000002", id_inst[31:0], id_pc[31:0]); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL adel_halt: got %b want 0", req_valid); end
    req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    cycle();
    redirect_valid = 1'b0;
    #1;
    checks++; if (req_valid !== 1'b1 || req_pc !== 32'h8000_0100 || id_valid !== 2'b00) begin errors++; $display("FAIL adel_exit: got %b %h %b want 1 80000100 00", req_valid, req_pc, id_valid); end
  endtask

  task automatic test_reset_mid();
    req_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      rsp_valid = 1'b0;
      cycle();
      rsp_valid = 1'b1; rsp_inst = {$urandom, $urandom};
      cycle();
    end
    rsp_valid = 1'b0; id_take = 2'd1;
    cycle();
    id_take = 2'd0; req_ready = 1'b0;
    #1;
    checks++; if (id_valid !== 2'b11 || id_pc[31:0] !== 32'h8000_0104 || req_valid !== 1'b0) begin errors++; $display("FAIL mid_setup: got %b %h %b want 11 80000104 0", id_valid, id_pc[31:0], req_valid); end
    reset = 1'b0;
    cycle();
    #1;
    checks++; if (id_valid !== 2'b00 || req_pc !== RPC || req_valid !== 1'b0) begin errors++; $display("FAIL mid_reset: got %b %h %b want 00 %h 0", id_valid, req_pc, req_valid, RPC); end
    reset = 1'b1;
    #1;
    checks++; if (req_valid !== 1'b1) begin errors++; $display("FAIL mid_release: got %b want 1", req_valid); end
  endtask

  task automatic test_random();
    bit busy = 0;
    int lat = 0;
    bit hs, was_rsp, ok;
    logic        ev, ea;
    logic [31:0] ei, ep;
    for (int c = 0; c < 3000; c++) begin
      id_take   = 2'($urandom_range(0, 2));
      req_ready = ($urandom_range(0, 3) != 0);
      rsp_valid = busy && (lat == 0);
      rsp_inst  = {$urandom, $urandom};
      exc_req   = ($urandom_range(0, 99) == 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0: redirect_pc = {$urandom_range(0, 32'hffff), 16'h0} | 32'h2;
        1: redirect_pc = {$urandom, 2'b00} & 32'hffff_fffc | 32'h4;
        default: redirect_pc = $urandom & 32'hffff_fffc;
      endcase
      #1;
      checks++;
      if (req_valid !== m_req_valid() || req_pc !== {m_fpc[31:3], 3'b000}) begin
        errors++; $display("FAIL rand_req cyc %0d: got %b %h want %b %h", c, req_valid, req_pc, m_req_valid(), {m_fpc[31:3], 3'b000});
      end
      for (int i = 0; i < IW; i++) begin
        ok = (i < mq.size());
        ev = ok;
        ei = ok ? mq[i].inst : 32'd0;
        ep = ok ? mq[i].pc   : 32'd0;
        ea = ok ? mq[i].adel : 1'b0;
        checks++;
        if (id_valid[i] !== ev || id_inst[32*i +: 32] !== ei || id_pc[32*i +: 32] !== ep || id_adel[i] !== ea) begin
          errors++; $display("FAIL rand_slot%0d cyc %0d: got %b %h %h %b want %b %h %h %b", i, c,
                             id_valid[i], id_inst[32*i +: 32], id_pc[32*i +: 32], id_adel[i], ev, ei, ep, ea);
        end
      end
      hs = m_req_valid() && req_ready;
      was_rsp = rsp_valid;
      cycle();
      if (was_rsp) busy = 0;
      else if (busy && lat > 0) lat--;
      if (hs) begin busy = 1; lat = $urandom_range(0, 2); end
    end
    exc_req = 1'b0; redirect_valid = 1'b0; rsp_valid = 1'b0; req_ready = 1'b0; id_take = 2'd0;
  endtask

  initial begin
    reset = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_inst = '0;
    redirect_valid = 1'b0; redirect_pc = '0; exc_req = 1'b0; id_take = 2'd0;
    m_fpc = RPC; m_wait = 0; m_halt = 0; m_drop = 0;
    @(negedge clk);
    test_reset();
    test_first_fetch();
    test_redirect_wait();
    test_credit();
    test_exc_redirect();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
